timer_arbiter: RTL and testbench

//   Shares one countdown timer among N_REQ requesters (traffic controller, crosswalk

---
 rtl/timer_arbiter.sv | 134 +++++++++++++
 tb/tb_timer_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/timer_arbiter.sv
// timer_arbiter: shares one countdown timer among N_REQ requesters.
// Grants round-robin, loads the shared timer with the winner's duration,
// enables it until it reaches zero, then pulses done for that requester.
// Ports:
//   clk, rst          clock (rising edge), synchronous active-low reset
//   req[N_REQ]        level request per requester, held until done or abort
//   dur[N_REQ*W]      durations, requester i uses dur[i*W +: W]
//   grant[N_REQ]      one-hot owner indication in LOAD and RUN
//   done[N_REQ]       one-cycle completion pulse for the owner
//   busy              high in any state other than IDLE
//   timer_en/load/init  control of the shared timer
//   timer_out         current value of the shared timer
module timer_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] dur,
  output logic [N_REQ-1:0]   grant,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic               timer_en,
  output logic               timer_load,
  output logic [W-1:0]       timer_init,
  input  logic [W-1:0]       timer_out
);

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

  state_t         state;
  logic [IW-1:0]  ptr;
  logic [IW-1:0]  owner;
  logic [W-1:0]   dur_q;

  logic [W-1:0]     dur_arr [N_REQ];
  logic             pick_vld;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    owner_inc;
  logic [N_REQ-1:0] owner_oh;
  int unsigned      idx;

  // Unpack the flat duration bus
  for (genvar i = 0; i < N_REQ; i++) begin : g_dur
    assign dur_arr[i] = dur[i*W +: W];
  end

  // Owner after the current one; it becomes lowest priority next round
  assign owner_inc = (32'(owner) == N_REQ - 1) ? '0 : owner + IW'(1);
  assign owner_oh  = N_REQ'(1) << owner;

  // Round-robin pick: first set request scanning ptr, ptr+1, ... modulo N_REQ
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    idx      = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!pick_vld && req[idx]) begin
        pick_vld = 1'b1;
        pick_idx = IW'(idx);
      end
    end
  end

  // State, owner, pointer and latched duration
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      owner <= '0;
      dur_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            owner <= pick_idx;
            dur_q <= dur_arr[pick_idx];
            state <= LOAD;
          end
        end
        LOAD: state <= RUN;
        RUN: begin
          // Dropped request aborts without a done pulse
          if (!req[owner]) begin
            ptr   <= owner_inc;
            state <= IDLE;
          end else if (timer_out == '0) begin
            state <= DONE;
          end
        end
        DONE: begin
          ptr   <= owner_inc;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from state/owner; req only matters in RUN
  always_comb begin
    grant      = '0;
    done       = '0;
    busy       = 1'b0;
    timer_en   = 1'b0;
    timer_load = 1'b0;
    timer_init = '0;
    case (state)
      LOAD: begin
        grant      = owner_oh;
        busy       = 1'b1;
        timer_load = 1'b1;
        timer_init = dur_q;
      end
      RUN: begin
        grant    = owner_oh;
        busy     = 1'b1;
        // Stop at zero so the timer never wraps
        timer_en = req[owner] && (timer_out != '0);
      end
      DONE: begin
        done = owner_oh;
        busy = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_timer_arbiter.sv
module tb_timer_arbiter;

  localparam int unsigned N_REQ = 3;
  localparam int unsigned W     = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] dur;
  logic [N_REQ-1:0]   grant;
  logic [N_REQ-1:0]   done;
  logic               busy;
  logic               timer_en;
  logic               timer_load;
  logic [W-1:0]       timer_init;
  logic [W-1:0]       timer_out = '0;

  int checks = 0;
  int errors = 0;
  int en_cnt;
  logic [N_REQ-1:0] exp_g;
  logic [N_REQ-1:0] exp_d;

  timer_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .dur        (dur),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .timer_en   (timer_en),
    .timer_load (timer_load),
    .timer_init (timer_init),
    .timer_out  (timer_out)
  );

  always #5 clk = ~clk;

  // Shared timer: load wins over en, en decrements
  always @(posedge clk) begin
    if (timer_load)    timer_out <= timer_init;
    else if (timer_en) timer_out <= timer_out - W'(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_dur(input logic [W-1:0] d2, input logic [W-1:0] d1, input logic [W-1:0] d0);
    dur = {d2, d1, d0};
  endtask

  initial begin
    // 1: reset held with all requests asserted
    rst = 1'b0;
    req = 3'b111;
    set_dur(4'd0, 4'd0, 4'd0);
    repeat (2) begin
      tick();
      chk("rst_grant", 32'(grant), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_en", 32'(timer_en), 0);
      chk("rst_load", 32'(timer_load), 0);
    end
    rst = 1'b1;
    req = 3'b000;
    tick();

    // 2: single request from requester 1, duration 5
    set_dur(4'd0, 4'd5, 4'd0);
    req = 3'b010;
    #1;
    chk("t2_c_busy", 32'(busy), 0);
    chk("t2_c_grant", 32'(grant), 0);
    en_cnt = 0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      en_cnt += int'(timer_en);
      if (k == 1) begin
        chk("t2_load_grant", 32'(grant), 32'b010);
        chk("t2_load", 32'(timer_load), 1);
        chk("t2_init", 32'(timer_init), 5);
        chk("t2_load_en", 32'(timer_en), 0);
      end else if (k <= 7) begin
        chk("t2_run_grant", 32'(grant), 32'b010);
        chk("t2_run_out", 32'(timer_out), 32'(7 - k));
        chk("t2_run_en", 32'(timer_en), (k <= 6) ? 1 : 0);
        chk("t2_run_init", 32'(timer_init), 0);
        chk("t2_run_done", 32'(done), 0);
      end else if (k == 8) begin
        chk("t2_done", 32'(done), 32'b010);
        chk("t2_done_grant", 32'(grant), 0);
        chk("t2_done_busy", 32'(busy), 1);
        req = 3'b000;
      end else begin
        chk("t2_idle_busy", 32'(busy), 0);
        chk("t2_idle_done", 32'(done), 0);
      end
    end
    chk("t2_en_cycles", 32'(en_cnt), 5);

    // 3: zero duration completes without enabling the timer
    set_dur(4'd0, 4'd0, 4'd0);
    req = 3'b001;
    tick();
    chk("t3_load_grant", 32'(grant), 32'b001);
    chk("t3_load", 32'(timer_load), 1);
    chk("t3_init", 32'(timer_init), 0);
    tick();
    chk("t3_run_grant", 32'(grant), 32'b001);
    chk("t3_run_en", 32'(timer_en), 0);
    chk("t3_run_done", 32'(done), 0);
    tick();
    chk("t3_done", 32'(done), 32'b001);
    chk("t3_done_grant", 32'(grant), 0);
    req = 3'b000;
    tick();
    chk("t3_idle_busy", 32'(busy), 0);

    // 4: all requesting, round-robin order 0,1,2,0
    rst = 1'b0;
    tick();
    rst = 1'b1;
    set_dur(4'd1, 4'd3, 4'd2);
    req = 3'b111;
    for (int k = 1; k <= 23; k++) begin
      tick();
      exp_g = 3'b000;
      exp_d = 3'b000;
      if (k >= 1 && k <= 4)   exp_g = 3'b001;
      if (k >= 7 && k <= 11)  exp_g = 3'b010;
      if (k >= 14 && k <= 16) exp_g = 3'b100;
      if (k >= 19 && k <= 22) exp_g = 3'b001;
      if (k == 5 || k == 23)  exp_d = 3'b001;
      if (k == 12)            exp_d = 3'b010;
      if (k == 17)            exp_d = 3'b100;
      chk("t4_grant", 32'(grant), 32'(exp_g));
      chk("t4_done", 32'(done), 32'(exp_d));
      chk("t4_onehot", 32'($onehot0(grant)), 1);
      if (k == 23) req = 3'b000;
    end
    tick();

    // 5: abort by dropping the request on the third RUN cycle
    set_dur(4'd0, 4'd2, 4'd9);
    req = 3'b001;
    tick();
    chk("t5_load_grant", 32'(grant), 32'b001);
    chk("t5_init", 32'(timer_init), 9);
    tick();
    chk("t5_run1_en", 32'(timer_en), 1);
    tick();
    tick();
    req = 3'b010;
    #1;
    chk("t5_drop_en", 32'(timer_en), 0);
    chk("t5_drop_grant", 32'(grant), 32'b001);
    tick();
    chk("t5_idle_done", 32'(done), 0);
    chk("t5_idle_grant", 32'(grant), 0);
    chk("t5_idle_busy", 32'(busy), 0);
    tick();
    chk("t5_next_grant", 32'(grant), 32'b010);
    chk("t5_next_init", 32'(timer_init), 2);

    // 6: reset while requester 2 owns the timer
    rst = 1'b0;
    req = 3'b000;
    tick();
    rst = 1'b1;
    set_dur(4'd4, 4'd0, 4'd0);
    req = 3'b100;
    tick();
    chk("t6_load_grant", 32'(grant), 32'b100);
    tick();
    tick();
    chk("t6_run_grant", 32'(grant), 32'b100);
    chk("t6_run_en", 32'(timer_en), 1);
    rst = 1'b0;
    req = 3'b111;
    tick();
    chk("t6_rst_grant", 32'(grant), 0);
    chk("t6_rst_done", 32'(done), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_en", 32'(timer_en), 0);
    chk("t6_rst_load", 32'(timer_load), 0);
    chk("t6_rst_init", 32'(timer_init), 0);
    rst = 1'b1;
    tick();
    chk("t6_first_grant", 32'(grant), 32'b001);
    chk("t6_first_load", 32'(timer_load), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
